// File: rtl/bridge_req_fifo.sv
// Request/data FIFO feeding the AXI4-Lite to APB converter: registered status, sticky errors, flush.
// Define BRIDGE_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module bridge_req_fifo #(
  parameter int unsigned dataWidth = 32,
  parameter int unsigned depth     = 4,
  parameter int unsigned afLevel   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [dataWidth-1:0]     wdata_i,
  input  logic                     pop_i,
  output logic [dataWidth-1:0]     rdata_o,
  input  logic                     flush_i,
  input  logic                     clr_err_i,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic [$clog2(depth):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int unsigned AddrW = $clog2(depth);
  localparam logic        AfRst = (afLevel >= depth);

  logic [dataWidth-1:0] mem_q [depth];

  logic [AddrW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic           empty_q, empty_d, full_q, full_d, af_q, af_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           push_ok, pop_ok;
  logic [31:0]    free_d;

  // Flush overrides both requests so neither moves a pointer nor raises an error.
  assign push_ok = push_i && !full_q && !flush_i;
  assign pop_ok  = pop_i && !empty_q && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end
    count_d = wptr_d - rptr_d;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AddrW-1:0] == rptr_d[AddrW-1:0]) && (wptr_d[AddrW] != rptr_d[AddrW]);
    free_d  = depth - 32'(count_d);
    af_d    = (free_d <= afLevel);
  end

  // Set wins over clear when a new error lands in the same cycle as clr_err.
  always_comb begin
    ovf_d = ovf_q && !clr_err_i;
    unf_d = unf_q && !clr_err_i;
    if (push_i && full_q && !flush_i) ovf_d = 1'b1;
    if (pop_i && empty_q && !flush_i) unf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= AfRst;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

`ifdef BRIDGE_FIFO_FWFT_EN
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];
`else
  logic [dataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (pop_ok) begin
      rdata_q <= mem_q[rptr_q[AddrW-1:0]];
    end
  end

  assign rdata_o = rdata_q;
`endif

  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign count_o       = count_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;

endmodule
